lcv_dot_prod_acc: RTL

// - Streaming signed dot-product engine: accepts (a,b) operand pairs on a valid/ready stream, multiplies, accumulates per vector.
// - A vector ends on the pair flagged in_last; its sum, term count and overflow flag are emitted as one result beat.
// - Sits downstream of the multiply-accumulate DSP stage; its output feeds the registered adder/collector stage.

---
 rtl/lcv_mul_acc_pkg.sv | 29 ++
 rtl/lcv_dot_prod_acc_add.sv | 56 +++++
 rtl/lcv_dot_prod_acc.sv | 118 +++++++++++
 3 files changed

// File: rtl/lcv_mul_acc_pkg.sv
// Shared definitions for the streaming dot-product engine.
//   - Default operand, accumulator and term-counter widths.
//   - sat_max / sat_min: largest / smallest signed value of a given width,
//     returned in the low 'width' bits of a 64-bit word.
//   - lcv_dp_result_t: one result beat (sum, term count, overflow flag) at
//     the default widths.
package lcv_mul_acc_pkg;

  localparam int LCV_MAC_IN_WIDTH  = 16;
  localparam int LCV_MAC_ACC_WIDTH = 33;
  localparam int LCV_MAC_CNT_WIDTH = 16;

  // 2**(width-1)-1 in the low 'width' bits.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // -2**(width-1) in the low 'width' bits (upper bits are sign fill).
  function automatic logic [63:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

  typedef struct packed {
    logic signed [LCV_MAC_ACC_WIDTH-1:0] sum;
    logic [LCV_MAC_CNT_WIDTH-1:0]        cnt;
    logic                                ovf;
  } lcv_dp_result_t;

endpackage

// File: rtl/lcv_dot_prod_acc_add.sv
// Accumulate-stage datapath: adds one product to the running sum.
//   first  : this product starts a new vector (running sum/ovf ignored)
//   acc    : running sum
//   ovf    : running sticky overflow flag
//   prod   : signed product, 2*IN_WIDTH bits
//   acc_n  : next running sum (wrapped, or clamped when LCV_DOT_PROD_SAT_EN)
//   ovf_n  : next sticky overflow flag
// Build option LCV_DOT_PROD_SAT_EN: clamp to the signed ACC_WIDTH range on
// overflow instead of wrapping.
module lcv_dot_prod_acc_add
  import lcv_mul_acc_pkg::*;
#(
  parameter int IN_WIDTH  = LCV_MAC_IN_WIDTH,
  parameter int ACC_WIDTH = LCV_MAC_ACC_WIDTH
) (
  input  logic                          first,
  input  logic signed [ACC_WIDTH-1:0]   acc,
  input  logic                          ovf,
  input  logic signed [2*IN_WIDTH-1:0]  prod,
  output logic signed [ACC_WIDTH-1:0]   acc_n,
  output logic                          ovf_n
);

  localparam int PW = 2 * IN_WIDTH;

  logic signed [ACC_WIDTH:0] base_x;
  logic signed [ACC_WIDTH:0] prod_x;
  logic signed [ACC_WIDTH:0] sum;
  logic                      overflow;

  // One guard bit above ACC_WIDTH: the top two bits disagree exactly when
  // the true sum is outside the signed ACC_WIDTH range.
  assign base_x   = first ? '0 : {acc[ACC_WIDTH-1], acc};
  assign prod_x   = {{(ACC_WIDTH + 1 - PW){prod[PW-1]}}, prod};
  assign sum      = base_x + prod_x;
  assign overflow = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  assign ovf_n    = (first ? 1'b0 : ovf) | overflow;

`ifdef LCV_DOT_PROD_SAT_EN
  localparam logic [63:0] MAX64 = sat_max(ACC_WIDTH);
  localparam logic [63:0] MIN64 = sat_min(ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = MAX64[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = MIN64[ACC_WIDTH-1:0];

  // The guard bit carries the true sign of the out-of-range sum.
  always_comb begin
    acc_n = sum[ACC_WIDTH-1:0];
    if (overflow) begin
      acc_n = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign acc_n = sum[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/lcv_dot_prod_acc.sv
// Streaming signed dot-product engine.
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_a/in_b/in_last : operand-pair stream
//   out_valid/out_ready/out_sum/out_cnt/out_ovf : one result beat per vector
// Pipeline: S1 registers a*b, S2 accumulates and, on the last pair, loads
// the result register. A pair with in_last seen at edge N is visible as
// out_valid=1 after edge N+1 of S1 -> S2, i.e. two edges after it is driven.
// Handshake: a beat moves on any edge where valid & ready are both high;
// valid never depends on ready. The whole pipeline freezes while a result
// is held un-accepted (stall), and in_ready drops for exactly that time.
// Build option LCV_DOT_PROD_SAT_EN selects clamping accumulation.
module lcv_dot_prod_acc
  import lcv_mul_acc_pkg::*;
#(
  parameter int IN_WIDTH  = LCV_MAC_IN_WIDTH,
  parameter int ACC_WIDTH = LCV_MAC_ACC_WIDTH,
  parameter int CNT_WIDTH = LCV_MAC_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_a,
  input  logic signed [IN_WIDTH-1:0]  in_b,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0]        out_cnt,
  output logic                        out_ovf
);

  localparam int PW = 2 * IN_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic stall;
  logic xfer;

  // S1
  logic                 v1;
  logic                 last1;
  logic signed [PW-1:0] p1;
  logic signed [PW-1:0] prod;

  // S2 running state
  logic                        first;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        ovf;
  logic signed [ACC_WIDTH-1:0] acc_n;
  logic                        ovf_n;
  logic [CNT_WIDTH-1:0]        cnt_n;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign xfer     = in_valid & in_ready;

  assign prod  = PW'(in_a) * PW'(in_b);
  assign cnt_n = first ? CNT_WIDTH'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);

  lcv_dot_prod_acc_add #(
    .IN_WIDTH  (IN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .first (first),
    .acc   (acc),
    .ovf   (ovf),
    .prod  (p1),
    .acc_n (acc_n),
    .ovf_n (ovf_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1        <= 1'b0;
      last1     <= 1'b0;
      p1        <= '0;
      first     <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_ovf   <= 1'b0;
    end else if (!stall) begin
      v1 <= xfer;
      if (xfer) begin
        p1    <= prod;
        last1 <= in_last;
      end

      if (v1) begin
        first <= last1;
        if (last1) begin
          out_sum <= acc_n;
          out_cnt <= cnt_n;
          out_ovf <= ovf_n;
          acc     <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
        end else begin
          acc <= acc_n;
          cnt <= cnt_n;
          ovf <= ovf_n;
        end
      end

      // A fresh load takes priority over draining the previous beat.
      if (v1 && last1) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
